// File: rtl/pool_window_feeder.sv
// pool_window_feeder: buffers one row of a raster pixel stream, issues 2x2 windows to max_pooling, streams pooled results
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_data/in_valid/in_ready   raster-order pixel stream in
//   im/en/input_ready           window, enable and issue strobe to max_pooling
//   om/done                     pooled result from max_pooling
//   out_data/out_valid/out_ready/out_last  pooled pixel stream out, last marks end of frame
module pool_window_feeder #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IL+FL-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SIZE-1:0][IL+FL-1:0]    im,
    output logic                          en,
    output logic                          input_ready,
    input  logic [IL+FL-1:0]              om,
    input  logic                          done,
    output logic [IL+FL-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);
    localparam int W  = IL + FL;
    localparam int CW = $clog2(MAP_W);
    localparam int RW = $clog2(MAP_H);
    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  left;
    logic [W-1:0]  rowbuf [MAP_W];
    logic          last_win;
    logic          acc;
    logic          col_end;
    logic          row_end;

    // en doubles as "out of reset" so in_ready stays low until the first clock after release
    assign in_ready    = en && state == FILL;
    assign input_ready = state == ISSUE;
    assign acc         = in_valid && in_ready;
    assign col_end     = col == CW'(MAP_W - 1);
    assign row_end     = row == RW'(MAP_H - 1);

    always_ff @(posedge clk) begin
        if (acc && !row[0])
            rowbuf[col] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            left      <= '0;
            last_win  <= 1'b0;
            en        <= 1'b0;
            im        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            en <= 1'b1;
            case (state)
                FILL: if (acc) begin
                    col <= col_end ? '0 : col + CW'(1);
                    if (col_end)
                        row <= row_end ? '0 : row + RW'(1);
                    // odd row, odd col completes a window; col-1 is the even column above-left
                    if (row[0] && col[0]) begin
                        im       <= {in_data, left, rowbuf[col], rowbuf[col - CW'(1)]};
                        last_win <= row_end && col_end;
                        state    <= ISSUE;
                    end else if (row[0]) begin
                        left <= in_data;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (done) begin
                    out_data  <= om;
                    out_valid <= 1'b1;
                    out_last  <= last_win;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
